battle_board: RTL and testbench
===============================

BATTLE_BOARD -- requirements
Module: battle_board

Interface
REQ-001 The block SHALL have parameter N, default 10, meaning board side length in cells (2..16).
REQ-002 The block SHALL have parameter NUM_BOARDS, default 2, meaning the number of independent boards (host, guest, ...).
REQ-003 The block SHALL have parameter MAX_SHIPS, default 10, meaning the maximum number of ship cells per board.
REQ-004 The block SHALL use derived widths CW = $clog2(N), BW = max(1, $clog2(NUM_BOARDS)) and SW = $clog2(MAX_SHIPS+1).
REQ-005 The block SHALL have port clk, input, 1, the single clock.
REQ-006 The block SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-007 The block SHALL have port cmd_valid, input, 1, command request.
REQ-008 The block SHALL have port cmd_ready, output, 1, command accept enable.
REQ-009 The block SHALL have port cmd_op, input, 2, command code: 00 PLACE, 01 SHOOT, 10 CLEAR, 11 reserved.
REQ-010 The block SHALL have port cmd_board, input, BW, target board index.
REQ-011 The block SHALL have ports cmd_x and cmd_y, input, CW each, target column and target row.
REQ-012 The block SHALL have port rsp_valid, output, 1, a one-cycle response strobe.
REQ-013 The block SHALL have port rsp_status, output, 3, response code: 000 OK, 001 MISS, 010 HIT, 011 SUNK_ALL, 100 REPEAT, 101 REJECT.
REQ-014 The block SHALL have ports rd_board (input, BW), rd_x (input, CW) and rd_y (input, CW), display read address.
REQ-015 The block SHALL have port rd_code, output, 2, cell code: 00 empty, 01 ship, 10 miss, 11 hit.
REQ-016 The block SHALL have port ships_left, output, NUM_BOARDS*SW, the unhit ship cells per board, with board b at bits [b*SW +: SW].
REQ-017 The block SHALL have port all_sunk, output, NUM_BOARDS, asserted per board when placed > 0 and ships_left == 0.

Function
REQ-018 The FSM SHALL have states IDLE, EXEC and CLEAR, and cmd_ready SHALL be 1 only in IDLE.
REQ-019 A command SHALL be accepted when cmd_valid && cmd_ready, with operands latched in that cycle; IDLE->CLEAR for a valid CLEAR command, otherwise IDLE->EXEC.
REQ-020 EXEC SHALL perform the read-modify-write, assert rsp_valid for exactly one cycle in the following cycle, and return to IDLE, giving 2-cycle accept-to-response latency and one command per 2 cycles maximum.
REQ-021 The block SHALL respond REJECT with no state change when cmd_x >= N, cmd_y >= N, cmd_board >= NUM_BOARDS or cmd_op == 11.
REQ-022 PLACE on an empty cell with placed[b] < MAX_SHIPS SHALL write 01, increment placed[b] and ships_left[b], and respond OK.
REQ-023 PLACE on a non-empty cell or with placed[b] == MAX_SHIPS SHALL respond REJECT with no change, so the count never exceeds MAX_SHIPS.
REQ-024 PLACE on a board that has received any SHOOT since its last clear SHALL respond REJECT.
REQ-025 SHOOT on 00 SHALL write 10 and respond MISS.
REQ-026 SHOOT on 01 SHALL write 11 and decrement ships_left[b], responding SUNK_ALL if ships_left[b] becomes 0 and HIT otherwise.
REQ-027 SHOOT on 10 or 11 SHALL respond REPEAT with no change.
REQ-028 CLEAR SHALL zero placed[b], ships_left[b] and the shot flag on entry, then write 00 to one cell per cycle in row-major order (N*N cycles).
REQ-029 After the last CLEAR cell is written, rsp_valid SHALL assert with OK in the next cycle, and other boards SHALL remain untouched.
REQ-030 The read port SHALL return rd_code registered with 1-cycle latency, independent of the FSM.
REQ-031 A read of a cell being written in the same cycle SHALL return the old value.
REQ-032 A read with an out-of-range rd_x, rd_y or rd_board SHALL return 00.
REQ-033 Counters SHALL never wrap: ships_left decrements only on a 01->11 transition, and placed is capped at MAX_SHIPS.
REQ-034 cmd_* inputs SHALL be ignored while cmd_ready is 0.

Reset
REQ-035 When rst is 1 at a clock edge, all cells of all boards SHALL be set to 00, with no preset ships.
REQ-036 Reset SHALL set placed, ships_left and the shot flags to 0, the state to IDLE, rsp_valid to 0, rsp_status to 000, rd_code to 00 and all_sunk to 0.
REQ-037 cmd_ready SHALL be 0 during rst and 1 in the first cycle after rst deasserts.
REQ-038 Reset during CLEAR or EXEC SHALL abort the operation with no response strobe.

Verification
REQ-039 The bench SHALL cover: after reset, PLACE b0 (3,4) -> OK at +2 cycles; a read of (3,4) -> 01; ships_left[b0]=1.
REQ-040 The bench SHALL cover: 10 PLACEs on distinct cells of b0, then an 11th PLACE -> REJECT, ships_left=10; a PLACE on an occupied cell -> REJECT.
REQ-041 The bench SHALL cover: one ship at b1 (0,0); SHOOT b1 (1,1) -> MISS with cell 10; SHOOT (0,0) -> SUNK_ALL with all_sunk[1]=1; SHOOT (0,0) again -> REPEAT.
REQ-042 The bench SHALL cover: SHOOT b0, then PLACE b0 -> REJECT; cmd_x=N -> REJECT; cmd_op=11 -> REJECT.
REQ-043 The bench SHALL cover: CLEAR b0 with N=10 -> cmd_ready low 100 cycles, then OK, with b0 all 00 and b1 unchanged.
REQ-044 The bench SHALL cover: rst asserted mid-CLEAR -> no rsp_valid, all boards 00, cmd_ready=1 the cycle after rst drops.

Source files
------------

// File: rtl/battle_board.sv
// battle_board: several independent battleship grids sharing one command/response
// port (place, shoot, clear) plus a free-running registered display read port.
module battle_board #(
    parameter int N          = 10,
    parameter int NUM_BOARDS = 2,
    parameter int MAX_SHIPS  = 10,
    localparam int CW = $clog2(N),
    localparam int BW = (NUM_BOARDS > 1) ? $clog2(NUM_BOARDS) : 1,
    localparam int SW = $clog2(MAX_SHIPS + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [BW-1:0]            cmd_board,
    input  logic [CW-1:0]            cmd_x,
    input  logic [CW-1:0]            cmd_y,
    output logic                     rsp_valid,
    output logic [2:0]               rsp_status,
    input  logic [BW-1:0]            rd_board,
    input  logic [CW-1:0]            rd_x,
    input  logic [CW-1:0]            rd_y,
    output logic [1:0]               rd_code,
    output logic [NUM_BOARDS*SW-1:0] ships_left,
    output logic [NUM_BOARDS-1:0]    all_sunk
);

    localparam int CELLS = N * N;
    localparam int TOTAL = NUM_BOARDS * CELLS;
    localparam int IW    = $clog2(CELLS);

    localparam logic [1:0] OP_PLACE = 2'b00;
    localparam logic [1:0] OP_SHOOT = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam logic [2:0] ST_OK       = 3'b000;
    localparam logic [2:0] ST_MISS     = 3'b001;
    localparam logic [2:0] ST_HIT      = 3'b010;
    localparam logic [2:0] ST_SUNK_ALL = 3'b011;
    localparam logic [2:0] ST_REPEAT   = 3'b100;
    localparam logic [2:0] ST_REJECT   = 3'b101;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_SHIP  = 2'b01;
    localparam logic [1:0] CELL_MISS  = 2'b10;
    localparam logic [1:0] CELL_HIT   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_CLEAR
    } state_t;

    state_t state;

    // All boards live in one flat array so reset can wipe every cell in a single edge.
    logic [1:0]            grid   [TOTAL];
    logic [SW-1:0]         placed [NUM_BOARDS];
    logic [SW-1:0]         ships  [NUM_BOARDS];
    logic [NUM_BOARDS-1:0] shot;

    logic [1:0]    lat_op;
    logic [BW-1:0] lat_board;
    logic [CW-1:0] lat_x;
    logic [CW-1:0] lat_y;
    logic          lat_ok;
    logic [IW-1:0] clr_idx;

    int         exec_idx;
    logic [1:0] exec_cell;
    int         clr_base;
    int         rd_idx;
    logic       rd_ok;

    function automatic logic addr_ok(input logic [BW-1:0] b,
                                     input logic [CW-1:0] x,
                                     input logic [CW-1:0] y);
        return (int'(b) < NUM_BOARDS) && (int'(x) < N) && (int'(y) < N);
    endfunction

    function automatic int cell_index(input logic [BW-1:0] b,
                                      input logic [CW-1:0] x,
                                      input logic [CW-1:0] y);
        return int'(b) * CELLS + int'(y) * N + int'(x);
    endfunction

    // The command port only listens in IDLE, and never while reset is held.
    assign cmd_ready = (state == S_IDLE) && !rst;

    // Address decode for the latched command and the read port; out-of-range addresses park at 0.
    always_comb begin
        exec_idx  = 0;
        exec_cell = CELL_EMPTY;
        clr_base  = int'(lat_board) * CELLS;
        rd_ok     = addr_ok(rd_board, rd_x, rd_y);
        rd_idx    = 0;
        if (lat_ok) begin
            exec_idx  = cell_index(lat_board, lat_x, lat_y);
            exec_cell = grid[exec_idx];
        end
        if (rd_ok) begin
            rd_idx = cell_index(rd_board, rd_x, rd_y);
        end
    end

    // Command FSM: latch in IDLE, read-modify-write in EXEC, sweep one cell per cycle in CLEAR.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            rsp_valid  <= 1'b0;
            rsp_status <= ST_OK;
            lat_op     <= OP_PLACE;
            lat_board  <= '0;
            lat_x      <= '0;
            lat_y      <= '0;
            lat_ok     <= 1'b0;
            clr_idx    <= '0;
            shot       <= '0;
            for (int b = 0; b < NUM_BOARDS; b++) begin
                placed[b] <= '0;
                ships[b]  <= '0;
            end
            for (int i = 0; i < TOTAL; i++) begin
                grid[i] <= CELL_EMPTY;
            end
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        lat_op    <= cmd_op;
                        lat_board <= cmd_board;
                        lat_x     <= cmd_x;
                        lat_y     <= cmd_y;
                        lat_ok    <= addr_ok(cmd_board, cmd_x, cmd_y) && (cmd_op != OP_RSVD);
                        if ((cmd_op == OP_CLEAR) && addr_ok(cmd_board, cmd_x, cmd_y)) begin
                            placed[cmd_board] <= '0;
                            ships[cmd_board]  <= '0;
                            shot[cmd_board]   <= 1'b0;
                            clr_idx           <= '0;
                            state             <= S_CLEAR;
                        end else begin
                            state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    rsp_valid <= 1'b1;
                    state     <= S_IDLE;
                    if (!lat_ok) begin
                        rsp_status <= ST_REJECT;
                    end else if (lat_op == OP_PLACE) begin
                        if (shot[lat_board] || (exec_cell != CELL_EMPTY) ||
                            (placed[lat_board] == SW'(MAX_SHIPS))) begin
                            rsp_status <= ST_REJECT;
                        end else begin
                            grid[exec_idx]    <= CELL_SHIP;
                            placed[lat_board] <= placed[lat_board] + SW'(1);
                            ships[lat_board]  <= ships[lat_board] + SW'(1);
                            rsp_status        <= ST_OK;
                        end
                    end else if (lat_op == OP_SHOOT) begin
                        shot[lat_board] <= 1'b1;
                        if (exec_cell == CELL_EMPTY) begin
                            grid[exec_idx] <= CELL_MISS;
                            rsp_status     <= ST_MISS;
                        end else if (exec_cell == CELL_SHIP) begin
                            grid[exec_idx]   <= CELL_HIT;
                            ships[lat_board] <= ships[lat_board] - SW'(1);
                            rsp_status       <= (ships[lat_board] == SW'(1)) ? ST_SUNK_ALL : ST_HIT;
                        end else begin
                            rsp_status <= ST_REPEAT;
                        end
                    end else begin
                        rsp_status <= ST_REJECT;
                    end
                end
                S_CLEAR: begin
                    grid[clr_base + int'(clr_idx)] <= CELL_EMPTY;
                    if (clr_idx == IW'(CELLS - 1)) begin
                        rsp_valid  <= 1'b1;
                        rsp_status <= ST_OK;
                        state      <= S_IDLE;
                    end else begin
                        clr_idx <= clr_idx + IW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Display read: registered, sees the pre-write value of a cell updated on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_code <= CELL_EMPTY;
        end else if (rd_ok) begin
            rd_code <= grid[rd_idx];
        end else begin
            rd_code <= CELL_EMPTY;
        end
    end

    // Per-board counters flattened onto the status outputs.
    always_comb begin
        ships_left = '0;
        all_sunk   = '0;
        for (int b = 0; b < NUM_BOARDS; b++) begin
            ships_left[b*SW +: SW] = ships[b];
            all_sunk[b]            = (placed[b] != '0) && (ships[b] == '0);
        end
    end

endmodule

// File: tb/tb_battle_board.sv
// tb_battle_board: directed scenarios plus randomized commands against a board model
// that tracks cells as plain integers and derives all counts by scanning the grid.
module tb_battle_board;

    localparam int N    = 10;
    localparam int NB   = 2;
    localparam int MAXS = 10;
    localparam int CW   = $clog2(N);
    localparam int BW   = (NB > 1) ? $clog2(NB) : 1;
    localparam int SW   = $clog2(MAXS + 1);

    localparam int OP_PLACE = 0;
    localparam int OP_SHOOT = 1;
    localparam int OP_CLEAR = 2;
    localparam int OP_RSVD  = 3;

    localparam int ST_OK       = 0;
    localparam int ST_MISS     = 1;
    localparam int ST_HIT      = 2;
    localparam int ST_SUNK_ALL = 3;
    localparam int ST_REPEAT   = 4;
    localparam int ST_REJECT   = 5;

    logic              clk;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [BW-1:0]     cmd_board;
    logic [CW-1:0]     cmd_x;
    logic [CW-1:0]     cmd_y;
    logic              rsp_valid;
    logic [2:0]        rsp_status;
    logic [BW-1:0]     rd_board;
    logic [CW-1:0]     rd_x;
    logic [CW-1:0]     rd_y;
    logic [1:0]        rd_code;
    logic [NB*SW-1:0]  ships_left;
    logic [NB-1:0]     all_sunk;

    int vectors;
    int miscompares;

    // Reference model: cell codes 0 empty, 1 ship, 2 miss, 3 hit, plus shot-since-clear flags.
    int model_grid [NB][N][N];
    bit model_shot [NB];

    battle_board #(
        .N          (N),
        .NUM_BOARDS (NB),
        .MAX_SHIPS  (MAXS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_board  (cmd_board),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .rsp_valid  (rsp_valid),
        .rsp_status (rsp_status),
        .rd_board   (rd_board),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_code    (rd_code),
        .ships_left (ships_left),
        .all_sunk   (all_sunk)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something upstream hangs despite the bounded waits.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

    task automatic checkOutput(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit in_range(input int b, input int x, input int y);
        return (b >= 0) && (b < NB) && (x >= 0) && (x < N) && (y >= 0) && (y < N);
    endfunction

    function automatic int model_read(input int b, input int x, input int y);
        if (!in_range(b, x, y)) return 0;
        return model_grid[b][y][x];
    endfunction

    // Unhit ships are simply the cells still showing a ship.
    function automatic int ship_count(input int b);
        int n = 0;
        for (int y = 0; y < N; y++)
            for (int x = 0; x < N; x++)
                if (model_grid[b][y][x] == 1) n++;
        return n;
    endfunction

    // Every placed ship is either still a ship or has become a hit.
    function automatic int placed_count(input int b);
        int n = 0;
        for (int y = 0; y < N; y++)
            for (int x = 0; x < N; x++)
                if (model_grid[b][y][x] == 1 || model_grid[b][y][x] == 3) n++;
        return n;
    endfunction

    function automatic void model_reset();
        for (int b = 0; b < NB; b++) begin
            model_shot[b] = 1'b0;
            for (int y = 0; y < N; y++)
                for (int x = 0; x < N; x++)
                    model_grid[b][y][x] = 0;
        end
    endfunction

    // Apply one command to the model and return the response it should produce.
    function automatic int model_exec(input int op, input int b, input int x, input int y);
        if (op == OP_RSVD || !in_range(b, x, y)) return ST_REJECT;
        case (op)
            OP_PLACE: begin
                if (model_shot[b] || model_grid[b][y][x] != 0 || placed_count(b) >= MAXS)
                    return ST_REJECT;
                model_grid[b][y][x] = 1;
                return ST_OK;
            end
            OP_SHOOT: begin
                model_shot[b] = 1'b1;
                if (model_grid[b][y][x] == 0) begin
                    model_grid[b][y][x] = 2;
                    return ST_MISS;
                end
                if (model_grid[b][y][x] == 1) begin
                    model_grid[b][y][x] = 3;
                    return (ship_count(b) == 0) ? ST_SUNK_ALL : ST_HIT;
                end
                return ST_REPEAT;
            end
            default: begin
                model_shot[b] = 1'b0;
                for (int yy = 0; yy < N; yy++)
                    for (int xx = 0; xx < N; xx++)
                        model_grid[b][yy][xx] = 0;
                return ST_OK;
            end
        endcase
    endfunction

    // Compare the per-board counter outputs against counts derived from the model grid.
    task automatic checkCounters();
        for (int b = 0; b < NB; b++) begin
            checkOutput("ships_left", int'(ships_left[b*SW +: SW]), ship_count(b));
            checkOutput("all_sunk", int'(all_sunk[b]),
                        (placed_count(b) > 0 && ship_count(b) == 0) ? 1 : 0);
        end
    endtask

    task automatic readCell(input int b, input int x, input int y, output int code);
        rd_board = BW'(b);
        rd_x     = CW'(x);
        rd_y     = CW'(y);
        @(posedge clk); #1;
        code = int'(rd_code);
    endtask

    task automatic checkBoard(input int b);
        int code;
        for (int y = 0; y < N; y++)
            for (int x = 0; x < N; x++) begin
                readCell(b, x, y, code);
                checkOutput("board_cell", code, model_read(b, x, y));
            end
    endtask

    // Issue one command, jam junk on the port while busy, and check response, latency,
    // busy duration, same-edge read behaviour, counters and the single-cycle strobe.
    task automatic applyStimulus(input int op, input int b, input int x, input int y,
                                 output int status);
        int guard;
        int lat;
        int ready_low;
        int old_code;
        int exp_status;
        int exp_lat;
        bit is_sweep;

        guard = 0;
        while (!cmd_ready && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("ready_wait", int'(cmd_ready), 1);

        is_sweep  = (op == OP_CLEAR) && in_range(b, x, y);
        exp_lat   = is_sweep ? (N * N + 1) : 2;
        old_code  = model_read(b, x, y);
        cmd_op    = 2'(op);
        cmd_board = BW'(b);
        cmd_x     = CW'(x);
        cmd_y     = CW'(y);
        rd_board  = BW'(b);
        rd_x      = CW'(x);
        rd_y      = CW'(y);
        cmd_valid = 1'b1;
        @(posedge clk); #1;

        cmd_op    = 2'($urandom);
        cmd_board = BW'($urandom_range(0, NB - 1));
        cmd_x     = CW'($urandom);
        cmd_y     = CW'($urandom);
        lat       = 1;
        ready_low = 0;
        while (!rsp_valid && lat < 400) begin
            if (!cmd_ready) ready_low++;
            @(posedge clk); #1;
            if (lat == 1) cmd_valid = 1'b0;
            lat++;
        end
        cmd_valid = 1'b0;

        exp_status = model_exec(op, b, x, y);
        status     = int'(rsp_status);
        checkOutput("rsp_seen", int'(rsp_valid), 1);
        checkOutput("rsp_status", status, exp_status);
        checkOutput("latency", lat, exp_lat);
        checkOutput("busy_cycles", ready_low, exp_lat - 1);
        if (!is_sweep) checkOutput("rd_old_value", int'(rd_code), old_code);
        checkCounters();
        @(posedge clk); #1;
        checkOutput("rsp_pulse", int'(rsp_valid), 0);
    endtask

    initial begin
        int st;
        int code;
        int op;
        int b;
        int x;
        int y;
        int r;
        int guard;

        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = '0;
        cmd_board   = '0;
        cmd_x       = '0;
        cmd_y       = '0;
        rd_board    = '0;
        rd_x        = '0;
        rd_y        = '0;
        model_reset();

        // Reset: port is closed while rst is held, open the first cycle after it drops.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("ready_in_rst", int'(cmd_ready), 0);
        rst = 1'b0;
        #1;
        checkOutput("ready_after_rst", int'(cmd_ready), 1);
        checkOutput("rsp_valid_rst", int'(rsp_valid), 0);
        checkOutput("rsp_status_rst", int'(rsp_status), ST_OK);
        checkOutput("rd_code_rst", int'(rd_code), 0);
        checkCounters();

        // First placement, readback, and a second placement on the same cell.
        applyStimulus(OP_PLACE, 0, 3, 4, st);
        readCell(0, 3, 4, code);
        checkOutput("read_3_4", code, 1);
        checkOutput("ships_left_b0_one", int'(ships_left[SW-1:0]), 1);
        applyStimulus(OP_PLACE, 0, 3, 4, st);
        checkOutput("place_occupied", st, ST_REJECT);

        // Fill board 0 up to the ship limit, then one more is refused.
        for (int i = 0; i < MAXS - 1; i++) applyStimulus(OP_PLACE, 0, i, 0, st);
        applyStimulus(OP_PLACE, 0, 9, 9, st);
        checkOutput("place_over_cap", st, ST_REJECT);
        checkOutput("ships_left_b0_cap", int'(ships_left[SW-1:0]), MAXS);

        // Board 1: single ship, miss, sink, repeat.
        applyStimulus(OP_PLACE, 1, 0, 0, st);
        applyStimulus(OP_SHOOT, 1, 1, 1, st);
        checkOutput("shoot_miss", st, ST_MISS);
        readCell(1, 1, 1, code);
        checkOutput("miss_cell", code, 2);
        applyStimulus(OP_SHOOT, 1, 0, 0, st);
        checkOutput("shoot_sunk", st, ST_SUNK_ALL);
        checkOutput("all_sunk_b1", int'(all_sunk[1]), 1);
        applyStimulus(OP_SHOOT, 1, 0, 0, st);
        checkOutput("shoot_repeat", st, ST_REPEAT);

        // Clear board 0: busy for the whole sweep, then board 0 empty and board 1 intact.
        applyStimulus(OP_CLEAR, 0, 0, 0, st);
        checkOutput("clear_ok", st, ST_OK);
        checkBoard(0);
        checkBoard(1);

        // Placement is locked after a shot; bad coordinates and reserved op are refused.
        applyStimulus(OP_SHOOT, 0, 5, 5, st);
        applyStimulus(OP_PLACE, 0, 6, 6, st);
        checkOutput("place_after_shot", st, ST_REJECT);
        applyStimulus(OP_PLACE, 1, N, 2, st);
        checkOutput("x_out_of_range", st, ST_REJECT);
        applyStimulus(OP_SHOOT, 1, 2, N, st);
        checkOutput("y_out_of_range", st, ST_REJECT);
        applyStimulus(OP_RSVD, 1, 2, 2, st);
        checkOutput("reserved_op", st, ST_REJECT);

        // Out-of-range display reads always come back empty.
        for (int i = 0; i < 4; i++) begin
            readCell(1, $urandom_range(N, (1 << CW) - 1), $urandom_range(0, N - 1), code);
            checkOutput("rd_oob", code, 0);
        end

        // Randomized command mix; clears are rare because each one sweeps the whole board.
        for (int i = 0; i < 300; i++) begin
            r  = $urandom_range(0, 99);
            op = (r < 48) ? OP_PLACE : (r < 92) ? OP_SHOOT : (r < 96) ? OP_CLEAR : OP_RSVD;
            b  = $urandom_range(0, NB - 1);
            x  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, (1 << CW) - 1)
                                             : $urandom_range(0, N - 1);
            y  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, (1 << CW) - 1)
                                             : $urandom_range(0, N - 1);
            applyStimulus(op, b, x, y, st);
        end
        checkBoard(0);
        checkBoard(1);

        // Put something on board 1 so the reset below has work to undo.
        applyStimulus(OP_CLEAR, 1, 0, 0, st);
        applyStimulus(OP_PLACE, 1, 4, 4, st);

        // Reset in the middle of a clear: no response, everything empty, port reopens at once.
        guard = 0;
        while (!cmd_ready && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        cmd_op    = 2'(OP_CLEAR);
        cmd_board = BW'(1);
        cmd_x     = '0;
        cmd_y     = '0;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            checkOutput("no_rsp_mid_clear", int'(rsp_valid), 0);
        end
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            checkOutput("no_rsp_in_rst", int'(rsp_valid), 0);
            checkOutput("ready_in_rst2", int'(cmd_ready), 0);
        end
        rst = 1'b0;
        #1;
        checkOutput("ready_after_rst2", int'(cmd_ready), 1);
        model_reset();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkOutput("no_rsp_after_abort", int'(rsp_valid), 0);
        end
        checkCounters();
        checkBoard(0);
        checkBoard(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
